// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops plus iterative 1-bit-per-cycle shifts.
// Issue is stalled through o_ready while a shift is in flight. Result and branch
// condition are registered and announced with a one-cycle o_valid pulse.
//
// state  | meaning
// IDLE   | ready to accept; single-cycle ops complete at the accepting edge
// SHIFT  | iterating a latched shift, one bit per edge, counter counts down to 1
module alu_exec_unit #(
    parameter int DATA_SIZE     = 32,
    parameter int ALU_CTRL_SIZE = 4,
    parameter int SHAMT_SIZE    = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_flush,
    input  logic [ALU_CTRL_SIZE-1:0] i_alu_ctrl,
    input  logic                     i_shamt_ctrl,
    input  logic                     i_last_register_ctrl,
    input  logic [DATA_SIZE-1:0]     i_data_a,
    input  logic [DATA_SIZE-1:0]     i_data_b,
    input  logic [SHAMT_SIZE-1:0]    i_shamt,
    input  logic [DATA_SIZE-1:0]     i_return_addr,
    output logic [DATA_SIZE-1:0]     o_result,
    output logic                     o_branch_taken,
    output logic                     o_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [ALU_CTRL_SIZE-1:0] OP_SLL = ALU_CTRL_SIZE'(0);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_SRL = ALU_CTRL_SIZE'(1);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_SRA = ALU_CTRL_SIZE'(2);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_ADD = ALU_CTRL_SIZE'(3);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_SUB = ALU_CTRL_SIZE'(4);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_AND = ALU_CTRL_SIZE'(5);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_OR  = ALU_CTRL_SIZE'(6);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_XOR = ALU_CTRL_SIZE'(7);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_NOR = ALU_CTRL_SIZE'(8);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_SLT = ALU_CTRL_SIZE'(9);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_LUI = ALU_CTRL_SIZE'(10);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_BEQ = ALU_CTRL_SIZE'(11);
    localparam logic [ALU_CTRL_SIZE-1:0] OP_BNE = ALU_CTRL_SIZE'(12);

    // direction codes latched for the iterative shifter
    localparam logic [1:0] DIR_SLL = 2'd0;
    localparam logic [1:0] DIR_SRL = 2'd1;
    localparam logic [1:0] DIR_SRA = 2'd2;

    state_t                  state_q, state_d;
    logic [DATA_SIZE-1:0]    result_q, result_d;
    logic                    taken_q, taken_d;
    logic                    valid_q, valid_d;
    logic [SHAMT_SIZE-1:0]   cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]    shreg_q, shreg_d;
    logic [1:0]              dir_q, dir_d;

    logic                    accept;
    logic                    is_shift;
    logic [SHAMT_SIZE-1:0]   amount;
    logic [DATA_SIZE-1:0]    alu_res;
    logic                    alu_taken;
    logic [DATA_SIZE-1:0]    shift_one;

    assign o_ready        = (state_q == ST_IDLE) && !i_reset;
    assign accept         = i_valid && o_ready && !i_flush;
    assign amount         = i_shamt_ctrl ? i_data_a[SHAMT_SIZE-1:0] : i_shamt;
    assign is_shift       = !i_last_register_ctrl &&
                            ((i_alu_ctrl == OP_SLL) || (i_alu_ctrl == OP_SRL) || (i_alu_ctrl == OP_SRA));
    assign o_result       = result_q;
    assign o_branch_taken = taken_q;
    assign o_valid        = valid_q;

    // single-cycle datapath; a zero-amount shift simply passes b through
    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        if (i_last_register_ctrl) begin
            alu_res = i_return_addr;
        end else begin
            case (i_alu_ctrl)
                OP_SLL, OP_SRL, OP_SRA: alu_res = i_data_b;
                OP_ADD: alu_res = i_data_a + i_data_b;
                OP_SUB: alu_res = i_data_a - i_data_b;
                OP_AND: alu_res = i_data_a & i_data_b;
                OP_OR:  alu_res = i_data_a | i_data_b;
                OP_XOR: alu_res = i_data_a ^ i_data_b;
                OP_NOR: alu_res = ~(i_data_a | i_data_b);
                OP_SLT: alu_res = ($signed(i_data_a) < $signed(i_data_b)) ? DATA_SIZE'(1) : '0;
                OP_LUI: alu_res = i_data_b << 16;
                OP_BEQ: begin
                    alu_res   = i_data_a - i_data_b;
                    alu_taken = (i_data_a == i_data_b);
                end
                OP_BNE: begin
                    alu_res   = i_data_a - i_data_b;
                    alu_taken = (i_data_a != i_data_b);
                end
                default: begin
                    alu_res   = '0;
                    alu_taken = 1'b0;
                end
            endcase
        end
    end

    // one-bit step of the latched shift
    always_comb begin
        case (dir_q)
            DIR_SLL: shift_one = {shreg_q[DATA_SIZE-2:0], 1'b0};
            DIR_SRL: shift_one = {1'b0, shreg_q[DATA_SIZE-1:1]};
            DIR_SRA: shift_one = {shreg_q[DATA_SIZE-1], shreg_q[DATA_SIZE-1:1]};
            default: shift_one = shreg_q;
        endcase
    end

    // next-state and register update logic
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        taken_d  = taken_q;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dir_d    = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (amount != '0)) begin
                        shreg_d = i_data_b;
                        cnt_d   = amount;
                        dir_d   = i_alu_ctrl[1:0];
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = alu_res;
                        taken_d  = alu_taken;
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (i_flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = shift_one;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_SIZE'(1)) begin
                        result_d = shift_one;
                        taken_d  = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            taken_q  <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dir_q    <= DIR_SLL;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            taken_q  <= taken_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dir_q    <= dir_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, randomized ops against a
// behavioural model, and hand-written flush / reset / back-to-back sequences.
`timescale 1ns/1ps
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_flush, i_shamt_ctrl, i_lrc;
    logic [3:0]  i_alu_ctrl;
    logic [31:0] i_data_a, i_data_b, i_return_addr;
    logic [4:0]  i_shamt;
    logic        o_ready, o_branch_taken, o_valid;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_SIZE(32), .ALU_CTRL_SIZE(4), .SHAMT_SIZE(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_alu_ctrl(i_alu_ctrl), .i_shamt_ctrl(i_shamt_ctrl),
        .i_last_register_ctrl(i_lrc), .i_data_a(i_data_a), .i_data_b(i_data_b),
        .i_shamt(i_shamt), .i_return_addr(i_return_addr), .o_result(o_result),
        .o_branch_taken(o_branch_taken), .o_valid(o_valid)
    );

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic        lrc;
        logic        sc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] ra;
        logic [31:0] exp_res;
        logic        exp_taken;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Behavioural reference: whole-word shifts and plain arithmetic.
    task automatic model(input logic [3:0] ctrl, input logic lrc, input logic sc,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] ra, output logic [31:0] r, output logic t,
                         output int lat);
        int n;
        n   = sc ? int'(a[4:0]) : int'(sh);
        t   = 1'b0;
        lat = 1;
        if (lrc) begin
            r = ra;
        end else begin
            case (ctrl)
                4'd0:  r = b << n;
                4'd1:  r = b >> n;
                4'd2:  r = $unsigned($signed(b) >>> n);
                4'd3:  r = a + b;
                4'd4:  r = a - b;
                4'd5:  r = a & b;
                4'd6:  r = a | b;
                4'd7:  r = a ^ b;
                4'd8:  r = ~(a | b);
                4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd10: r = {b[15:0], 16'h0};
                4'd11: begin r = a - b; t = (a == b); end
                4'd12: begin r = a - b; t = (a != b); end
                default: r = 32'd0;
            endcase
            if (ctrl <= 4'd2) lat = n + 1;
        end
    endtask

    task automatic scramble_inputs();
        i_valid       = 1'($urandom);
        i_alu_ctrl    = 4'($urandom);
        i_shamt_ctrl  = 1'($urandom);
        i_lrc         = 1'($urandom);
        i_data_a      = $urandom;
        i_data_b      = $urandom;
        i_shamt       = 5'($urandom);
        i_return_addr = $urandom;
    endtask

    task automatic drive(input logic [3:0] ctrl, input logic lrc, input logic sc,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] ra);
        i_valid = 1'b1; i_alu_ctrl = ctrl; i_lrc = lrc; i_shamt_ctrl = sc;
        i_data_a = a; i_data_b = b; i_shamt = sh; i_return_addr = ra;
    endtask

    // Issue one op, scramble inputs while it runs, then check result, timing and pulse width.
    task automatic run_op(input string nm, input logic [3:0] ctrl, input logic lrc,
                          input logic sc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] ra,
                          input logic [31:0] er, input logic et, input int elat);
        int  edges;
        int  lowcnt;
        bit  got;
        @(negedge clk);
        chk({nm, "_ready_pre"}, 32'(o_ready), 32'd1);
        drive(ctrl, lrc, sc, a, b, sh, ra);
        @(posedge clk);
        edges = 1; lowcnt = 0; got = 1'b0;
        #1 scramble_inputs();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid) begin got = 1'b1; break; end
            if (!o_ready) lowcnt++;
            @(posedge clk);
            edges++;
        end
        i_valid = 1'b0;
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: no o_valid within 40 cycles, expected latency %0d", nm, elat);
        end else begin
            chk({nm, "_result"}, o_result, er);
            chk({nm, "_taken"}, 32'(o_branch_taken), 32'(et));
            chk({nm, "_latency"}, 32'(edges), 32'(elat));
            chk({nm, "_ready_at_valid"}, 32'(o_ready), 32'd1);
            chk({nm, "_ready_low_cycles"}, 32'(lowcnt), 32'(elat - 1));
            @(negedge clk);
            chk({nm, "_valid_pulse"}, 32'(o_valid), 32'd0);
        end
        last_res = er;
    endtask

    task automatic start_sll10();
        @(negedge clk);
        drive(4'd0, 1'b0, 1'b0, 32'h0, 32'h1, 5'd10, 32'h0);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic        t;
        int          lat;
        logic [3:0]  c;
        logic        lrc, sc;
        logic [31:0] a, b, ra;
        logic [4:0]  sh;
        int          saw;

        vecs.push_back('{"add_ovf", 4'd3, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h0, 32'h80000000, 1'b0, 1});
        vecs.push_back('{"sra4", 4'd2, 1'b0, 1'b0, 32'h0, 32'h80000000, 5'd4, 32'h0, 32'hF8000000, 1'b0, 5});
        vecs.push_back('{"sllv3", 4'd0, 1'b0, 1'b1, 32'h23, 32'h1, 5'd7, 32'h0, 32'h8, 1'b0, 4});
        vecs.push_back('{"sllv0", 4'd0, 1'b0, 1'b1, 32'h20, 32'h1, 5'd7, 32'h0, 32'h1, 1'b0, 1});
        vecs.push_back('{"beq_eq", 4'd11, 1'b0, 1'b0, 32'h5, 32'h5, 5'd0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{"bne_eq", 4'd12, 1'b0, 1'b0, 32'h5, 32'h5, 5'd0, 32'h0, 32'h0, 1'b0, 1});
        vecs.push_back('{"bne_ne", 4'd12, 1'b0, 1'b0, 32'h1, 32'h2, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{"slt_neg", 4'd9, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h1, 1'b0, 1});
        vecs.push_back('{"lrc_sub", 4'd4, 1'b1, 1'b0, 32'h9, 32'h3, 5'd0, 32'h40, 32'h40, 1'b0, 1});
        vecs.push_back('{"code_e", 4'd14, 1'b0, 1'b0, 32'h9, 32'h3, 5'd0, 32'h40, 32'h0, 1'b0, 1});
        vecs.push_back('{"srl31", 4'd1, 1'b0, 1'b0, 32'h0, 32'hF0000000, 5'd31, 32'h0, 32'h1, 1'b0, 32});
        vecs.push_back('{"nor0", 4'd8, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1});
        vecs.push_back('{"lui", 4'd10, 1'b0, 1'b0, 32'h0, 32'hABCD1234, 5'd0, 32'h0, 32'h12340000, 1'b0, 1});
        vecs.push_back('{"sub_wrap", 4'd4, 1'b0, 1'b0, 32'h0, 32'h1, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1});
        vecs.push_back('{"lrc_shift", 4'd0, 1'b1, 1'b0, 32'h0, 32'h1, 5'd5, 32'h1234, 32'h1234, 1'b0, 1});
        vecs.push_back('{"beq_after_shift_taken", 4'd11, 1'b0, 1'b0, 32'h7, 32'h7, 5'd0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{"sll1_clears_taken", 4'd0, 1'b0, 1'b0, 32'h0, 32'h80000001, 5'd1, 32'h0, 32'h2, 1'b0, 2});

        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_alu_ctrl = 4'd0; i_shamt_ctrl = 1'b0;
        i_lrc = 1'b0; i_data_a = '0; i_data_b = '0; i_shamt = '0; i_return_addr = '0;
        last_res = '0;
        #1;
        chk("reset_ready_low", 32'(o_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_result", o_result, 32'd0);
        chk("reset_taken", 32'(o_branch_taken), 32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_reset", 32'(o_ready), 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].ctrl, vecs[i].lrc, vecs[i].sc, vecs[i].a, vecs[i].b,
                   vecs[i].sh, vecs[i].ra, vecs[i].exp_res, vecs[i].exp_taken, vecs[i].exp_lat);

        // back-to-back single-cycle ops
        @(negedge clk);
        drive(4'd3, 1'b0, 1'b0, 32'd1, 32'd2, 5'd0, 32'h0);
        @(posedge clk);
        #1 drive(4'd4, 1'b0, 1'b0, 32'd10, 32'd3, 5'd0, 32'h0);
        @(negedge clk);
        chk("b2b_valid1", 32'(o_valid), 32'd1);
        chk("b2b_result1", o_result, 32'd3);
        chk("b2b_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid2", 32'(o_valid), 32'd1);
        chk("b2b_result2", o_result, 32'd7);
        @(negedge clk);
        chk("b2b_idle", 32'(o_valid), 32'd0);
        last_res = 32'd7;

        // flush in the third SHIFT cycle
        start_sll10();
        chk("flush_ready_low", 32'(o_ready), 32'd0);
        i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        @(negedge clk);
        chk("flush_no_valid", 32'(o_valid), 32'd0);
        chk("flush_result_kept", o_result, last_res);
        chk("flush_ready", 32'(o_ready), 32'd1);
        saw = 0;
        repeat (12) begin @(negedge clk); if (o_valid) saw++; end
        chk("flush_no_late_valid", 32'(saw), 32'd0);

        // flush in IDLE beats i_valid
        @(negedge clk);
        drive(4'd3, 1'b0, 1'b0, 32'd100, 32'd1, 5'd0, 32'h0);
        i_flush = 1'b1;
        @(posedge clk);
        #1 begin i_flush = 1'b0; i_valid = 1'b0; end
        @(negedge clk);
        chk("idle_flush_no_valid", 32'(o_valid), 32'd0);
        chk("idle_flush_result_kept", o_result, last_res);

        // reset in the third SHIFT cycle
        run_op("bne_prime", 4'd12, 1'b0, 1'b0, 32'd9, 32'd4, 5'd0, 32'h0, 32'd5, 1'b1, 1);
        start_sll10();
        rst = 1'b1;
        #1;
        chk("rst_mid_result", o_result, 32'd0);
        chk("rst_mid_taken", 32'(o_branch_taken), 32'd0);
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (12) begin @(negedge clk); if (o_valid) saw++; end
        chk("rst_no_late_valid", 32'(saw), 32'd0);
        chk("rst_ready_after", 32'(o_ready), 32'd1);
        chk("rst_result_after", o_result, 32'd0);
        last_res = '0;

        // randomized ops against the model
        for (int i = 0; i < 80; i++) begin
            c   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) c = 4'($urandom_range(0, 2));
            lrc = ($urandom_range(0, 7) == 0);
            sc  = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            sh  = 5'($urandom);
            ra  = $urandom;
            model(c, lrc, sc, a, b, sh, ra, r, t, lat);
            run_op($sformatf("rand%0d", i), c, lrc, sc, a, b, sh, ra, r, t, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
